// File: rtl/write_fifo_drain.sv
// write_fifo_drain
//   Pops {address word, data word} pairs from the render write FIFO and issues
//   one 32-bit Avalon-MM master write per pair. This block is the only reader
//   of that FIFO and the only master on the pixel-write path.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   enable            1 = may start a new pair; 0 = finish the current pair, then idle
//   FF_empty, FF_q    FIFO status and read data (data valid the cycle after a pop)
//   FF_readrequest    FIFO pop strobe, one cycle per word
//   avm_*             Avalon-MM write master (byteenable is fixed at 4'hF)
//   busy              1 whenever the FSM is not IDLE
//   pair_count        writes accepted by the slave since reset, wraps silently
module write_fifo_drain #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             FF_empty,
    input  logic [31:0]      FF_q,
    output logic             FF_readrequest,
    output logic [31:0]      avm_address,
    output logic             avm_write,
    output logic [31:0]      avm_writedata,
    output logic [3:0]       avm_byteenable,
    input  logic             avm_waitrequest,
    output logic             busy,
    output logic [CNT_W-1:0] pair_count
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH_ADDR,
        WAIT_DATA,
        LATCH_DATA,
        WRITE
    } state_t;

    state_t             state_q, state_d;
    // Only bits [22:0] of the address word ever reach the bus.
    logic [22:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rdreq;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        rdreq   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !FF_empty) begin
                    rdreq   = 1'b1;
                    state_d = LATCH_ADDR;
                end
            end
            LATCH_ADDR: begin
                // enable is deliberately ignored: a started pair always completes.
                addr_d = FF_q[22:0];
                if (!FF_empty) begin
                    rdreq   = 1'b1;
                    state_d = LATCH_DATA;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (!FF_empty) begin
                    rdreq   = 1'b1;
                    state_d = LATCH_DATA;
                end
            end
            LATCH_DATA: begin
                data_d  = FF_q;
                state_d = WRITE;
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    cnt_d = cnt_q + CNT_ONE;
                    // Pop the next address word in the acceptance cycle so
                    // back-to-back pairs sustain one write every 3 cycles.
                    if (enable && !FF_empty) begin
                        rdreq   = 1'b1;
                        state_d = LATCH_ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rdreq is combinational from IDLE; gating with rst_n keeps the pop
    // strobe low while reset is held.
    assign FF_readrequest = rst_n & rdreq;
    assign avm_write      = (state_q == WRITE);
    assign avm_address    = avm_write ? (ADDR_BASE + {7'b0, addr_q, 2'b00}) : '0;
    assign avm_writedata  = avm_write ? data_q : '0;
    assign avm_byteenable = 4'hF;
    assign busy           = (state_q != IDLE);
    assign pair_count     = cnt_q;

endmodule

// File: tb/tb_write_fifo_drain.sv
// Bench for write_fifo_drain: a behavioural normal-mode FIFO feeds the DUT,
// expected {address, data} records go into a scoreboard queue as pairs are
// pushed and are popped when the slave accepts a write. The DUT is built with
// a high ADDR_BASE so every address exercises the modulo-2^32 sum.
module tb_write_fifo_drain;

    localparam logic [31:0] BASE = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        ff_empty;
    logic [31:0] ff_q;
    logic        ff_rd;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic        busy;
    logic [31:0] pair_count;

    write_fifo_drain #(
        .ADDR_BASE (BASE),
        .CNT_W     (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .FF_empty        (ff_empty),
        .FF_q            (ff_q),
        .FF_readrequest  (ff_rd),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .pair_count      (pair_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pop_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural FIFO (normal mode) ----------------
    logic        push_en;
    logic [31:0] push_data;
    logic [31:0] fifo[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo.delete();
            ff_q     <= '0;
            ff_empty <= 1'b1;
        end else begin
            if (ff_rd) begin
                check("pop_not_empty", {31'b0, ff_empty}, 32'd0);
                pop_cnt++;
                if (fifo.size() > 0) ff_q <= fifo.pop_front();
            end
            if (push_en) fifo.push_back(push_data);
            ff_empty <= (fifo.size() == 0);
        end
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          acc_t[$];

    always begin
        @(negedge clk);
        #2;
        if (rst_n && avm_write && !avm_waitrequest) begin
            acc_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_write", avm_address, 32'hxxxx_xxxx);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wr_addr", avm_address, e[63:32]);
                check("wr_data", avm_writedata, e[31:0]);
                check("wr_be", {28'b0, avm_byteenable}, 32'h0000_000F);
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0] addr_word;
        logic [31:0] data_word;
        logic [31:0] exp_addr;   // BASE + {addr_word[22:0],2'b00} mod 2^32
    } vec_t;
    vec_t vec[6];

    task automatic push_word(input logic [31:0] w);
        push_en   = 1'b1;
        push_data = w;
        @(negedge clk);
        push_en   = 1'b0;
    endtask

    task automatic queue_pair(input int i);
        exp_q.push_back({vec[i].exp_addr, vec[i].data_word});
        push_word(vec[i].addr_word);
        push_word(vec[i].data_word);
    endtask

    task automatic wait_pc(input int target);
        int n;
        n = 0;
        while (pair_count != target && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("pair_count_reached", pair_count, target);
    endtask

    task automatic wait_write();
        int n;
        n = 0;
        while (!avm_write && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("write_seen", {31'b0, avm_write}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [31:0] a0, d0;

        vec[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0030};
        vec[1] = '{32'hFF80_0005, 32'h1234_5678, 32'h0000_0004};
        vec[2] = '{32'h0000_0000, 32'hA5A5_A5A5, 32'hFFFF_FFF0};
        vec[3] = '{32'h007F_FFFF, 32'h0F0F_0F0F, 32'h01FF_FFEC};
        vec[4] = '{32'h8000_0003, 32'hCAFE_F00D, 32'hFFFF_FFFC};
        vec[5] = '{32'h0000_0004, 32'h0000_0001, 32'h0000_0000};

        rst_n = 1'b0; enable = 1'b1; avm_waitrequest = 1'b0;
        push_en = 1'b0; push_data = '0;
        repeat (2) @(negedge clk);
        check("rst_write", {31'b0, avm_write}, 32'd0);
        check("rst_addr", avm_address, 32'd0);
        check("rst_data", avm_writedata, 32'd0);
        check("rst_be", {28'b0, avm_byteenable}, 32'h0000_000F);
        check("rst_rd", {31'b0, ff_rd}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_count", pair_count, 32'd0);
        enable = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);

        // T1: single pair, pop-to-write latency of 3 cycles
        queue_pair(0);
        p0 = pop_cnt;
        enable = 1'b1;
        @(negedge clk);
        check("t1_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("t1_no_write_early", {31'b0, avm_write}, 32'd0);
        @(negedge clk);
        check("t1_write_at_3", {31'b0, avm_write}, 32'd1);
        check("t1_addr", avm_address, 32'h0000_0030);
        @(negedge clk);
        check("t1_write_done", {31'b0, avm_write}, 32'd0);
        check("t1_count", pair_count, 32'd1);
        check("t1_pops", pop_cnt - p0, 32'd2);
        check("t1_idle", {31'b0, busy}, 32'd0);

        // T2: 5-cycle stall, write held 6 cycles, counted once
        avm_waitrequest = 1'b1;
        queue_pair(1);
        wait_write();
        a0 = avm_address;
        d0 = avm_writedata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_write_held", {31'b0, avm_write}, 32'd1);
            check("t2_addr_stable", avm_address, a0);
            check("t2_data_stable", avm_writedata, d0);
            check("t2_count_held", pair_count, 32'd1);
        end
        avm_waitrequest = 1'b0;
        @(negedge clk);
        check("t2_write_drop", {31'b0, avm_write}, 32'd0);
        check("t2_count", pair_count, 32'd2);

        // T3: four preloaded pairs, back-to-back every 3 cycles
        enable = 1'b0;
        for (int i = 2; i < 6; i++) queue_pair(i);
        p0 = pop_cnt;
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("t3_busy", {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        check("t3_idle", {31'b0, busy}, 32'd0);
        check("t3_count", pair_count, 32'd6);
        check("t3_pops", pop_cnt - p0, 32'd8);
        if (acc_t.size() >= 4) begin
            for (int k = acc_t.size() - 3; k < acc_t.size(); k++)
                check("t3_interval", acc_t[k] - acc_t[k-1], 32'd3);
        end else begin
            check("t3_acc_log", acc_t.size(), 32'd4);
        end

        // T4: split pair, wait in WAIT_DATA with no pops on empty
        exp_q.push_back({vec[0].exp_addr, vec[0].data_word});
        p0 = pop_cnt;
        push_word(vec[0].addr_word);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check("t4_no_rd", {31'b0, ff_rd}, 32'd0);
            check("t4_busy", {31'b0, busy}, 32'd1);
            @(negedge clk);
        end
        push_word(vec[0].data_word);
        wait_pc(7);
        check("t4_pops", pop_cnt - p0, 32'd2);

        // T5: enable gating
        enable = 1'b0;
        queue_pair(1);
        queue_pair(2);
        p0 = pop_cnt;
        repeat (3) @(negedge clk);
        check("t5_idle", {31'b0, busy}, 32'd0);
        check("t5_no_pops", pop_cnt - p0, 32'd0);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_pc(8);
        repeat (3) @(negedge clk);
        check("t5_stopped", {31'b0, busy}, 32'd0);
        check("t5_one_pair", pop_cnt - p0, 32'd2);
        check("t5_count_hold", pair_count, 32'd8);
        enable = 1'b1;
        wait_pc(9);
        check("t5_drain_pops", pop_cnt - p0, 32'd4);
        check("sb_drained", exp_q.size(), 32'd0);

        // T6: asynchronous reset during a stalled write
        avm_waitrequest = 1'b1;
        queue_pair(3);
        wait_write();
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_write_async", {31'b0, avm_write}, 32'd0);
        check("t6_addr", avm_address, 32'd0);
        check("t6_count", pair_count, 32'd0);
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_be", {28'b0, avm_byteenable}, 32'h0000_000F);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        avm_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_post_idle", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
